// File: rtl/dm_port_arbiter.sv
// ---------------------------------------------------------------------------
// dm_port_arbiter
//   Shares the single data-memory port between the pipeline load/store path
//   (P) and the debug/file-loader path (D). Each access is granted from IDLE,
//   runs for MEM_LAT BUSY cycles on latched request fields, and then finishes
//   with a one-cycle DONE pulse to its owner. P normally wins a contested
//   grant. A starve counter forces a D grant after MAX_DBG_WAIT consecutive
//   contested P wins, so the debug path can never be locked out.
//
// Parameters
//   ADDR_W        data memory word-address width
//   DATA_W        data width
//   MEM_LAT       memory access cycles, legal 1..8
//   MAX_DBG_WAIT  contested P wins before D is forced, >= 1
//
// Ports
//   i_clk, i_rst_n                        clock (rising edge), async active-low reset
//   i_p_req/i_p_we/i_p_addr/i_p_wdata     pipeline request; held stable until o_p_done
//   o_p_stall                             pipeline freeze = i_p_req & ~o_p_done
//   o_p_done, o_p_rdata                   completion pulse, load data (held after done)
//   i_d_req/i_d_we/i_d_addr/i_d_wdata     debug request, same rules as pipeline
//   o_d_done, o_d_rdata                   completion pulse, load data (held after done)
//   o_mem_we/o_mem_addr/o_mem_wdata       memory write strobe, address, write data
//   i_mem_rdata                           memory read data
// ---------------------------------------------------------------------------
module dm_port_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int MEM_LAT      = 1,
  parameter int MAX_DBG_WAIT = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_p_req,
  input  logic              i_p_we,
  input  logic [ADDR_W-1:0] i_p_addr,
  input  logic [DATA_W-1:0] i_p_wdata,
  output logic              o_p_stall,
  output logic              o_p_done,
  output logic [DATA_W-1:0] o_p_rdata,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic              o_d_done,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  // MEM_LAT tops out at 8, so the remaining-cycle counter needs 3 bits.
  localparam int                CNT_W    = 3;
  localparam int                STV_W    = $clog2(MAX_DBG_WAIT + 1);
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(MEM_LAT - 1);
  localparam logic [STV_W-1:0]  STV_MAX  = STV_W'(MAX_DBG_WAIT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  logic                r_owner;     // 0 = pipeline, 1 = debug
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_first;     // set only during the first BUSY cycle
  logic [STV_W-1:0]    r_starve;
  logic [DATA_W-1:0]   r_p_rdata;
  logic [DATA_W-1:0]   r_d_rdata;

  logic                w_contested;
  logic                w_grant_d;
  logic                w_grant_p;
  logic                w_grant;
  logic                w_sel_we;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;

  // Arbitration: P wins a contest unless D has already lost MAX_DBG_WAIT
  // contests in a row.
  assign w_contested = i_p_req & i_d_req;
  assign w_grant_d   = i_d_req & (~i_p_req | (r_starve == STV_MAX));
  assign w_grant_p   = i_p_req & ~w_grant_d;
  assign w_grant     = w_grant_p | w_grant_d;

  assign w_sel_we    = w_grant_d ? i_d_we    : i_p_we;
  assign w_sel_addr  = w_grant_d ? i_d_addr  : i_p_addr;
  assign w_sel_wdata = w_grant_d ? i_d_wdata : i_p_wdata;

  // Next state and per-state strobes. mem_we is decoded from registered
  // state only, so an asynchronous reset removes it immediately.
  always_comb begin
    w_state_next = r_state;
    o_mem_we     = 1'b0;
    o_p_done     = 1'b0;
    o_d_done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          w_state_next = S_BUSY;
        end
      end
      S_BUSY: begin
        o_mem_we = r_we & r_first;
        if (r_cnt == '0) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        o_p_done     = ~r_owner;
        o_d_done     = r_owner;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign o_p_stall   = i_p_req & ~o_p_done;
  // Address and data come from the latched fields and keep their last value
  // through DONE and IDLE.
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_p_rdata   = r_p_rdata;
  assign o_d_rdata   = r_d_rdata;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_owner   <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_cnt     <= '0;
      r_first   <= 1'b0;
      r_starve  <= '0;
      r_p_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_owner <= w_grant_d;
            r_we    <= w_sel_we;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_cnt   <= CNT_INIT;
            r_first <= 1'b1;
            // Uncontested P grants leave the counter alone; only contested
            // P wins count towards forcing D.
            if (w_grant_d) begin
              r_starve <= '0;
            end else if (w_contested && (r_starve != STV_MAX)) begin
              r_starve <= r_starve + STV_W'(1);
            end
          end
        end
        S_BUSY: begin
          r_first <= 1'b0;
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else if (r_owner) begin
            r_d_rdata <= i_mem_rdata;
          end else begin
            r_p_rdata <= i_mem_rdata;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dm_port_arbiter
//   Two arbiter instances (MEM_LAT=1/MAX_DBG_WAIT=8 and MEM_LAT=4/
//   MAX_DBG_WAIT=2) driven by random requesters. A transaction-level model
//   predicts grant edges, memory strobes, done pulses and read data from
//   cycle arithmetic and a shadow memory. A final phase holds both requests
//   high and measures the number of P completions between D completions.
// ---------------------------------------------------------------------------
module tb_dm_port_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit timed_out = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Power-on memory contents; address 0x005 holds a recognisable pattern.
  function automatic logic [31:0] init_val(input logic [AW-1:0] a);
    if (a == 10'h005) return 32'hDEADBEEF;
    return {a, 22'h0} ^ 32'h5A5A_1234 ^ {22'h0, a};
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    case ($urandom_range(3))
      0:       return 10'h3FF;
      1:       return 10'h005;
      default: return AW'($urandom_range(15));
    endcase
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int LAT  = (gi == 0) ? 1 : 4;
    localparam int MAXW = (gi == 0) ? 8 : 2;

    logic          rst_n;
    logic          p_req, p_we, p_stall, p_done;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_wdata, p_rdata;
    logic          d_req, d_we, d_done;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    // Environment memory: combinational read, write on the rising edge.
    logic [DW-1:0] env_mem [0:1023];
    bit            written [0:1023];
    assign mem_rdata = written[mem_addr] ? env_mem[mem_addr] : init_val(mem_addr);
    always @(posedge clk) begin
      if (mem_we) begin
        env_mem[mem_addr] <= mem_wdata;
        written[mem_addr] <= 1'b1;
      end
    end

    dm_port_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .MAX_DBG_WAIT(MAXW)
    ) u_dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_p_req(p_req), .i_p_we(p_we), .i_p_addr(p_addr), .i_p_wdata(p_wdata),
      .o_p_stall(p_stall), .o_p_done(p_done), .o_p_rdata(p_rdata),
      .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
      .o_d_done(d_done), .o_d_rdata(d_rdata),
      .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
      .i_mem_rdata(mem_rdata)
    );

    // Reference model state. Edge e is the next rising edge; interval c is
    // the clock period that follows edge c.
    logic [DW-1:0] shadow [0:1023];
    int            e, next_free, starve;
    bit            has_acc, a_own, a_we;
    int            a_g;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wd, a_rd;
    int            p_st, d_st;        // 0 idle, 1 waiting, 2 granted
    logic [DW-1:0] exp_prd, exp_drd;
    bit            prd_ok, drd_ok;
    bit            gap_on, fin_i;
    int            cnt_p, gaps;

    function automatic string tg(input string s);
      return $sformatf("i%0d_%s", gi, s);
    endfunction

    task automatic model_reset();
      has_acc = 1'b0; next_free = 0; starve = 0;
      p_st = 0; d_st = 0;
      exp_prd = '0; exp_drd = '0; prd_ok = 1'b1; drd_ok = 1'b1;
      cnt_p = 0;
    endtask

    task automatic req_step(input bit force_on, input bit drop_ok,
                            input int st_i, input logic req_i, input logic we_i,
                            input logic [AW-1:0] addr_i, input logic [DW-1:0] wd_i,
                            output int st_o, output logic req_o, output logic we_o,
                            output logic [AW-1:0] addr_o, output logic [DW-1:0] wd_o);
      st_o = st_i; req_o = req_i; we_o = we_i; addr_o = addr_i; wd_o = wd_i;
      if (st_i == 0) begin
        req_o = force_on || ($urandom_range(7) < 5);
        st_o  = req_o ? 1 : 0;
        we_o = 1'($urandom_range(1)); addr_o = rand_addr(); wd_o = $urandom;
      end else if (st_i == 2) begin
        if (req_i && drop_ok && $urandom_range(9) == 0) req_o = 1'b0;
        // Once dropped, the fields are free to wander; the access in flight
        // must keep using what was captured at grant.
        if (!req_o) begin
          we_o = 1'($urandom_range(1)); addr_o = rand_addr(); wd_o = $urandom;
        end
      end
    endtask

    task automatic model_edge();
      bit gd;
      // A store lands in memory at the edge closing its first BUSY cycle.
      if (has_acc && a_we && e == a_g + 1) shadow[a_addr] = a_wd;
      if (e >= next_free && (p_req || d_req)) begin
        gd = d_req && (!p_req || starve == MAXW);
        if (gd) starve = 0;
        else if (d_req && starve < MAXW) starve++;
        a_own = gd;
        if (gd) begin a_we = d_we; a_addr = d_addr; a_wd = d_wdata; d_st = 2; end
        else    begin a_we = p_we; a_addr = p_addr; a_wd = p_wdata; p_st = 2; end
        a_rd = shadow[a_addr];
        a_g = e; has_acc = 1'b1;
        next_free = e + LAT + 2;
      end
      e++;
    endtask

    task automatic check_cycle();
      int c;
      bit busy, pd, dd;
      c    = e - 1;
      busy = has_acc && c >= a_g && c < a_g + LAT;
      pd   = has_acc && c == a_g + LAT && !a_own;
      dd   = has_acc && c == a_g + LAT && a_own;
      check_val(tg("mem_we"), mem_we, has_acc && c == a_g && a_we);
      check_val(tg("p_done"), p_done, pd);
      check_val(tg("d_done"), d_done, dd);
      check_val(tg("p_stall"), p_stall, p_req && !pd);
      check_val(tg("mem_addr"), mem_addr, has_acc ? a_addr : '0);
      if (busy) check_val(tg("mem_wdata"), mem_wdata, a_wd);
      if (pd || dd) begin
        $display("[i%0d] c=%0d %s %s addr=%03h data=%08h", gi, c, a_own ? "D" : "P",
                 a_we ? "ST" : "LD", a_addr, a_we ? a_wd : a_rd);
      end
      if (pd) begin
        p_st = 0; cnt_p++;
        prd_ok = !a_we; exp_prd = a_rd;
      end
      if (dd) begin
        d_st = 0;
        drd_ok = !a_we; exp_drd = a_rd;
        if (gap_on) begin
          check_val(tg("starve_gap"), cnt_p, MAXW);
          gaps++;
        end
        cnt_p = 0;
      end
      if (prd_ok) check_val(tg("p_rdata"), p_rdata, exp_prd);
      if (drd_ok) check_val(tg("d_rdata"), d_rdata, exp_drd);
    endtask

    task automatic apply_reset();
      rst_n = 1'b0; p_req = 1'b0; d_req = 1'b0;
      #1;
      check_val(tg("rst_mem_we"), mem_we, 0);
      check_val(tg("rst_p_done"), p_done, 0);
      check_val(tg("rst_d_done"), d_done, 0);
      check_val(tg("rst_p_stall"), p_stall, 0);
      check_val(tg("rst_mem_addr"), mem_addr, 0);
      check_val(tg("rst_mem_wdata"), mem_wdata, 0);
      check_val(tg("rst_p_rdata"), p_rdata, 0);
      check_val(tg("rst_d_rdata"), d_rdata, 0);
      @(negedge clk);
      @(negedge clk);
      e += 2;
      rst_n = 1'b1;
      model_reset();
    endtask

    task automatic run(input int n, input bit force_on, input bit rst_ok);
      for (int k = 0; k < n; k++) begin
        req_step(force_on, !force_on, p_st, p_req, p_we, p_addr, p_wdata,
                 p_st, p_req, p_we, p_addr, p_wdata);
        req_step(force_on, !force_on, d_st, d_req, d_we, d_addr, d_wdata,
                 d_st, d_req, d_we, d_addr, d_wdata);
        model_edge();
        @(negedge clk);
        check_cycle();
        // Abort a store during its write-strobe cycle now and then.
        if (rst_ok && has_acc && a_we && (e - 1) == a_g && $urandom_range(5) == 0)
          apply_reset();
      end
    endtask

    initial begin
      e = 0; gap_on = 1'b0; gaps = 0; fin_i = 1'b0;
      for (int i = 0; i < 1024; i++) shadow[i] = init_val(AW'(i));
      rst_n = 1'b1;
      p_req = 1'b0; p_we = 1'b0; p_addr = '0; p_wdata = '0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
      model_reset();
      #2;
      apply_reset();
      run(1500, 1'b0, 1'b1);
      apply_reset();
      gap_on = 1'b1;
      run(3 * (MAXW + 1) * (LAT + 2) + 10, 1'b1, 1'b0);
      check_val(tg("starve_rounds"), gaps >= 3, 1);
      gap_on = 1'b0;
      fin_i = 1'b1;
    end
  end

  initial begin
    fork
      begin
        wait (g_inst[0].fin_i && g_inst[1].fin_i);
      end
      begin
        #400000;
        timed_out = 1'b1;
      end
    join_any
    disable fork;
    check_val("run_complete", timed_out, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
